// File: rtl/udp_dram_pkg.sv
// Shared definitions for the UDP receiver DRAM writer: descriptor layout,
// AXI4 constants and the writer FSM encoding.
package udp_dram_pkg;

    // Descriptor layout in the control FIFO word
    localparam int unsigned LEN_MSB  = 39;
    localparam int unsigned LEN_LSB  = 32;
    localparam int unsigned ADDR_MSB = 31;

    // AXI4 constants
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_AW,
        S_W
    } state_e;

endpackage

// File: rtl/axi_boundary_split.sv
// Combinational burst sizing: clamps the remaining word count so that a burst
// never crosses a 4 KB address boundary.
module axi_boundary_split (
    input  logic [11:0] addr_lo,
    input  logic [8:0]  rem,
    output logic [8:0]  beats
);

    logic [12:0] words;

    // Words left before the next 4 KB boundary, then take the smaller count
    always_comb begin
        words = (13'h1000 - {1'b0, addr_lo}) >> 2;
        if (words < {4'b0000, rem}) begin
            beats = words[8:0];
        end else begin
            beats = rem;
        end
    end

endmodule

// File: rtl/udp_dram_axi_writer.sv
// Drains the receiver's descriptor and data FIFOs into AXI4 write bursts,
// splitting at 4 KB boundaries and tracking outstanding write responses.
module udp_dram_axi_writer
    import udp_dram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] ctrl_dout,
    input  logic        ctrl_empty,
    output logic        ctrl_re,
    input  logic [35:0] data_dout,
    input  logic        data_empty,
    output logic        data_re,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic        busy,
    output logic        err,
    output logic [15:0] burst_done_cnt
);

    // Five bits so a split second burst issued at the limit cannot wrap
    localparam logic [4:0] MaxOut = 5'(MAX_OUTSTANDING);

    state_e      state_q;
    logic [31:0] addr_q;
    logic [7:0]  rem_q;
    logic [8:0]  beats_q;
    logic [7:0]  beat_q;
    logic [4:0]  outstanding_q;
    logic        err_q;
    logic [15:0] cnt_q;

    logic [8:0]  beats_calc;
    logic [7:0]  last_idx;
    logic        can_issue;
    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;

    axi_boundary_split u_split (
        .addr_lo (addr_q[11:0]),
        .rem     ({1'b0, rem_q}),
        .beats   (beats_calc)
    );

    assign last_idx  = 8'(beats_q - 9'd1);
    assign can_issue = (outstanding_q < MaxOut);

    assign ctrl_re       = (state_q == S_IDLE) && !ctrl_empty && can_issue;
    assign m_axi_awvalid = (state_q == S_AW);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = last_idx;
    assign m_axi_awsize  = SIZE_4B;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_wvalid  = (state_q == S_W) && !data_empty;
    assign m_axi_wdata   = data_dout[31:0];
    assign m_axi_wstrb   = data_dout[35:32];
    assign m_axi_wlast   = (state_q == S_W) && (beat_q == last_idx);
    assign data_re       = m_axi_wvalid && m_axi_wready;
    assign m_axi_bready  = 1'b1;

    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;
    assign b_hs  = m_axi_bvalid;

    assign busy           = (state_q != S_IDLE) || (outstanding_q != 5'd0);
    assign err            = err_q;
    assign burst_done_cnt = cnt_q;

    // Burst sequencer: descriptor pop, size, address phase, data phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            beats_q <= '0;
            beat_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ctrl_re) begin
                        addr_q <= ctrl_dout[ADDR_MSB:0] + BASE_ADDR;
                        rem_q  <= ctrl_dout[LEN_MSB:LEN_LSB];
                        // Zero-length descriptors are dropped without a burst
                        if (ctrl_dout[LEN_MSB:LEN_LSB] != 8'd0) begin
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    beats_q <= beats_calc;
                    beat_q  <= '0;
                    state_q <= S_AW;
                end
                S_AW: begin
                    if (m_axi_awready) begin
                        state_q <= S_W;
                    end
                end
                S_W: begin
                    if (w_hs) begin
                        if (m_axi_wlast) begin
                            addr_q  <= addr_q + {21'b0, beats_q, 2'b00};
                            rem_q   <= rem_q - beats_q[7:0];
                            beat_q  <= '0;
                            state_q <= (rem_q != beats_q[7:0]) ? S_LOAD : S_IDLE;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Outstanding-response tracking; simultaneous AW and B cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_q <= '0;
        end else begin
            case ({aw_hs, b_hs})
                2'b10:   outstanding_q <= outstanding_q + 5'd1;
                2'b01:   if (outstanding_q != 5'd0) outstanding_q <= outstanding_q - 5'd1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // Completion counter and sticky error flag from the B channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (b_hs) begin
            cnt_q <= cnt_q + 16'd1;
            if (m_axi_bresp != RESP_OKAY) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_udp_dram_axi_writer.sv
// Directed bench for udp_dram_axi_writer with FWFT FIFO models, an AXI slave
// responder and a scoreboard of expected AW and W beats.
module tb_udp_dram_axi_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [39:0] ctrl_dout = '0;
    logic        ctrl_empty = 1'b1;
    logic        ctrl_re;
    logic [35:0] data_dout = '0;
    logic        data_empty = 1'b1;
    logic        data_re;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b1;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b1;
    logic [1:0]  m_axi_bresp = 2'b00;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic        busy;
    logic        err;
    logic [15:0] burst_done_cnt;

    always #5 clk = ~clk;

    udp_dram_axi_writer #(
        .BASE_ADDR       (32'h0000_0000),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ctrl_dout      (ctrl_dout),
        .ctrl_empty     (ctrl_empty),
        .ctrl_re        (ctrl_re),
        .data_dout      (data_dout),
        .data_empty     (data_empty),
        .data_re        (data_re),
        .m_axi_awaddr   (m_axi_awaddr),
        .m_axi_awlen    (m_axi_awlen),
        .m_axi_awsize   (m_axi_awsize),
        .m_axi_awburst  (m_axi_awburst),
        .m_axi_awvalid  (m_axi_awvalid),
        .m_axi_awready  (m_axi_awready),
        .m_axi_wdata    (m_axi_wdata),
        .m_axi_wstrb    (m_axi_wstrb),
        .m_axi_wlast    (m_axi_wlast),
        .m_axi_wvalid   (m_axi_wvalid),
        .m_axi_wready   (m_axi_wready),
        .m_axi_bresp    (m_axi_bresp),
        .m_axi_bvalid   (m_axi_bvalid),
        .m_axi_bready   (m_axi_bready),
        .busy           (busy),
        .err            (err),
        .burst_done_cnt (burst_done_cnt)
    );

    int tests = 0;
    int fails = 0;

    logic [39:0] ctrl_fifo[$];
    logic [35:0] data_fifo[$];
    logic [39:0] exp_aw[$];   // {awaddr, awlen}
    logic [36:0] exp_w[$];    // {wlast, wstrb, wdata}

    bit starve  = 1'b0;
    bit wr_rand = 1'b0;
    int b_allow = 1000000;
    int b_pending = 0;
    int resp_idx = 0;
    int bad_idx = -1;
    int aw_cnt = 0;
    int w_cnt = 0;
    int dseq = 0;
    int eseq = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] word_of(input int k);
        logic [31:0] d;
        d = 32'hA500_0000 + 32'(k);
        return {4'(k + 1), d};
    endfunction

    task automatic push_desc(input int len, input logic [31:0] addr);
        ctrl_fifo.push_back({8'(len), addr});
        for (int i = 0; i < len; i++) begin
            data_fifo.push_back(word_of(dseq));
            dseq++;
        end
    endtask

    task automatic exp_burst(input logic [31:0] addr, input int n);
        exp_aw.push_back({addr, 8'(n - 1)});
        for (int j = 0; j < n; j++) begin
            exp_w.push_back({(j == n - 1), word_of(eseq)});
            eseq++;
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i = 0;
        while ((exp_aw.size() != 0 || exp_w.size() != 0 || ctrl_fifo.size() != 0 || busy)
               && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 64'(i < budget), 64'd1);
    endtask

    // FIFO models, AXI slave and scoreboard; inputs update 1 time unit after the edge
    always @(posedge clk) begin
        logic [39:0] ea;
        logic [36:0] ew;
        if (rst) begin
            b_pending = 0;
        end else begin
            if (m_axi_awvalid && m_axi_awready) begin
                aw_cnt++;
                b_pending++;
                if (exp_aw.size() == 0) begin
                    chk("aw_unexpected", 64'd1, 64'd0);
                end else begin
                    ea = exp_aw.pop_front();
                    chk("aw", {m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst},
                        {ea, 3'b010, 2'b01});
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_cnt++;
                if (exp_w.size() == 0) begin
                    chk("w_unexpected", 64'd1, 64'd0);
                end else begin
                    ew = exp_w.pop_front();
                    chk("w_beat", {m_axi_wlast, m_axi_wstrb, m_axi_wdata, data_re}, {ew, 1'b1});
                end
            end else if (data_re) begin
                chk("data_re_spurious", 64'd1, 64'd0);
            end
            if (data_re && data_fifo.size() != 0) void'(data_fifo.pop_front());
            if (ctrl_re && ctrl_fifo.size() != 0) void'(ctrl_fifo.pop_front());
            if (m_axi_bvalid && m_axi_bready) begin
                b_pending--;
                b_allow--;
                resp_idx++;
            end
        end
        #1;
        ctrl_empty    = (ctrl_fifo.size() == 0);
        ctrl_dout     = ctrl_empty ? '0 : ctrl_fifo[0];
        data_empty    = starve || (data_fifo.size() == 0);
        data_dout     = (data_fifo.size() == 0) ? '0 : data_fifo[0];
        m_axi_awready = wr_rand ? 1'($urandom) : 1'b1;
        m_axi_wready  = wr_rand ? 1'($urandom) : 1'b1;
        m_axi_bvalid  = !rst && (b_pending > 0) && (b_allow > 0);
        m_axi_bresp   = (resp_idx == bad_idx) ? 2'b10 : 2'b00;
    end

    initial begin
        int base;
        int hi;
        int i;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {m_axi_awvalid, m_axi_wvalid, ctrl_re, data_re, busy, err, burst_done_cnt, m_axi_bready},
            {6'b000000, 16'd0, 1'b1});
        rst = 1'b0;
        @(negedge clk);

        // Single 64-beat burst
        push_desc(64, 32'h100);
        exp_burst(32'h100, 64);
        wait_done("t1_done", 500);
        chk("t1_cnt", 64'(burst_done_cnt), 64'd1);
        chk("t1_aw_cnt", 64'(aw_cnt), 64'd1);

        // 4 KB crossing splits into 2 + 14 beats
        push_desc(16, 32'hFF8);
        exp_burst(32'hFF8, 2);
        exp_burst(32'h1000, 14);
        wait_done("t2_done", 300);
        chk("t2_cnt", 64'(burst_done_cnt), 64'd3);
        chk("t2_aw_cnt", 64'(aw_cnt), 64'd3);

        // Zero-length descriptor is dropped silently
        push_desc(0, 32'h800);
        wait_done("t2z_done", 50);
        chk("t2z_aw_cnt", 64'(aw_cnt), 64'd3);

        // Outstanding limit with B responses withheld
        b_allow = 0;
        base = aw_cnt;
        for (int k = 0; k < 6; k++) begin
            push_desc(2, 32'h2000 + 32'(k * 16));
            exp_burst(32'h2000 + 32'(k * 16), 2);
        end
        repeat (80) @(negedge clk);
        chk("t3_aw_limit", 64'(aw_cnt - base), 64'd4);
        chk("t3_idle_stall", {m_axi_awvalid, busy}, 2'b01);
        b_allow = 1;
        repeat (20) @(negedge clk);
        chk("t3_aw_after_b", 64'(aw_cnt - base), 64'd5);
        b_allow = 1000000;
        wait_done("t3_done", 300);
        chk("t3_cnt", 64'(burst_done_cnt), 64'd9);

        // Data starvation mid-burst with random ready
        wr_rand = 1'b1;
        base = w_cnt;
        push_desc(32, 32'h3000);
        exp_burst(32'h3000, 32);
        i = 0;
        while (w_cnt < base + 10 && i < 400) begin
            @(negedge clk);
            i++;
        end
        chk("t4_reach_beat10", 64'(i < 400), 64'd1);
        starve = 1'b1;
        @(negedge clk);
        hi = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m_axi_wvalid) hi++;
        end
        chk("t4_starve_wvalid", 64'(hi), 64'd0);
        starve = 1'b0;
        wait_done("t4_done", 600);
        wr_rand = 1'b0;
        chk("t4_w_cnt", 64'(w_cnt - base), 64'd32);

        // SLVERR on the second of two bursts; err is sticky
        bad_idx = resp_idx + 1;
        push_desc(4, 32'h4000);
        exp_burst(32'h4000, 4);
        push_desc(4, 32'h4100);
        exp_burst(32'h4100, 4);
        wait_done("t5_done", 200);
        chk("t5_err_set", 64'(err), 64'd1);
        push_desc(4, 32'h4200);
        exp_burst(32'h4200, 4);
        wait_done("t5b_done", 200);
        chk("t5_err_sticky", 64'(err), 64'd1);
        chk("t5_cnt", 64'(burst_done_cnt), 64'd13);

        // Asynchronous reset in the middle of the data phase
        base = w_cnt;
        push_desc(32, 32'h5000);
        exp_burst(32'h5000, 32);
        i = 0;
        while (w_cnt < base + 20 && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("t6_reach_beat20", 64'(i < 200), 64'd1);
        chk("t6_busy_before", {busy, m_axi_wvalid}, 2'b11);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_async_drop", {m_axi_awvalid, m_axi_wvalid, busy, err}, 4'b0000);
        data_fifo.delete();
        exp_w.delete();
        exp_aw.delete();
        @(negedge clk);
        chk("t6_cnt_reset", 64'(burst_done_cnt), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        push_desc(4, 32'h6000);
        exp_burst(32'h6000, 4);
        wait_done("t6_done", 200);
        chk("t6_cnt_after", 64'(burst_done_cnt), 64'd1);
        chk("t6_err_after", 64'(err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/udp_dram_axi_writer.md
Name: udp_dram_axi_writer

Overview:
- Downstream stage of the UDP frame receiver.
- Drains the receiver's data FIFO (strb+data words) and control FIFO (len+addr descriptors) and issues AXI4 write bursts to the DRAM controller, one burst per descriptor.
- Splits any descriptor that crosses a 4 KB boundary into two bursts.
- Tracks outstanding write responses and reports completion and errors to the frame-select and status logic.

Parameters:
- BASE_ADDR, 32'h0000_0000, added to every descriptor address before issue.
- MAX_OUTSTANDING, 4, maximum AW bursts issued without a matching B response (1..15).

Ports:
- clk  in  1  system clock (single clock domain)
- rst  in  1  reset, asynchronous, active-high
- ctrl_dout  in  40  descriptor: [39:32] len in 32-bit words, [31:0] byte address
- ctrl_empty  in  1  control FIFO empty (FWFT: ctrl_dout valid when low)
- ctrl_re  out  1  control FIFO pop
- data_dout  in  36  [35:32] strobe, [31:0] data
- data_empty  in  1  data FIFO empty (FWFT)
- data_re  out  1  data FIFO pop
- m_axi_awaddr  out  32  burst start address
- m_axi_awlen  out  8  beats-1
- m_axi_awsize  out  3  constant 3'b010
- m_axi_awburst  out  2  constant 2'b01 (INCR)
- m_axi_awvalid / m_axi_awready  out / in  1 / 1  AW handshake
- m_axi_wdata  out  32  write data
- m_axi_wstrb  out  4  write strobe
- m_axi_wlast  out  1  last beat of burst
- m_axi_wvalid / m_axi_wready  out / in  1 / 1  W handshake
- m_axi_bresp  in  2  write response
- m_axi_bvalid / m_axi_bready  in / out  1 / 1  B handshake
- busy  out  1  any descriptor in progress or B outstanding
- err  out  1  sticky: a non-OKAY bresp was seen
- burst_done_cnt  out  16  wrapping count of accepted B responses

Behaviour:
- Reset (asynchronous):
  - All valids, ctrl_re, data_re, err, busy and burst_done_cnt clear to 0.
  - FSM returns to S_IDLE and the outstanding counter clears to 0.
  - Reset mid-burst abandons the burst; the FIFOs are reset by the same rst.
- FSM states: S_IDLE, S_LOAD, S_AW, S_W.
- S_IDLE:
  - If !ctrl_empty and outstanding < MAX_OUTSTANDING: pop the descriptor (ctrl_re=1 for one cycle), latch addr = ctrl_dout[31:0] + BASE_ADDR and rem = len, then go to S_LOAD.
  - len==0: the descriptor is popped and discarded; stay in S_IDLE; no AXI activity.
- S_LOAD: compute beats = min(rem, words to next 4 KB boundary), where words to boundary = (4096 - addr[11:0]) >> 2; go to S_AW.
- S_AW: awvalid=1 with awaddr=addr and awlen=beats-1; held stable until awready. On handshake: outstanding increments and the FSM goes to S_W.
- S_W:
  - wvalid = !data_empty; wdata/wstrb come straight from data_dout; data_re = wvalid & wready (same cycle, combinational).
  - wlast=1 on beat index beats-1. A starved FIFO simply stalls.
  - After the last beat handshakes: addr += beats*4 and rem -= beats.
  - If rem != 0: go to S_LOAD (second split burst). Else go to S_IDLE.
- AW and W are strictly sequential per burst: W never leads AW.
- B channel:
  - bready is held constantly at 1.
  - Each bvalid decrements outstanding and increments burst_done_cnt (wraps at 16 bits).
  - bresp != 2'b00 sets err, which is cleared only by rst.
  - An AW handshake and a B handshake in the same cycle leave outstanding unchanged.
- busy = (state != S_IDLE) | (outstanding != 0).
- Latency: descriptor pop to awvalid is 2 cycles.
- Widths: address arithmetic is 32-bit and wraps modulo 2^32; beats is 9 bits internally (max 64 in practice); the len field is used unsigned up to 255.

Decomposition:
- Shared package (udp_dram_pkg):
  - Descriptor field offsets (LEN_MSB=39, LEN_LSB=32, ADDR_MSB=31).
  - AXI constants: SIZE_4B, BURST_INCR, RESP_OKAY.
  - FSM state encoding.
- Sub-module axi_boundary_split: combinational beats calculator (addr, rem -> beats). All sequencing stays in the top.

Test Plan:
- Descriptor len=64, addr=0x100, data 0..63 preloaded, awready/wready=1 -> one AW (addr 0x100, awlen 63); 64 W beats with wlast on beat 63; one B; burst_done_cnt=1.
- len=16, addr=0xFF8, BASE_ADDR=0 -> two bursts: addr 0xFF8 awlen 1, then addr 0x1000 awlen 13; wlast asserted twice.
- 6 queued descriptors with bvalid withheld, MAX_OUTSTANDING=4 -> exactly 4 AW handshakes, then awvalid stays low; releasing one B allows the 5th AW.
- Data FIFO empty for 10 cycles mid-burst with random wready -> wvalid=0 during starvation; no beat lost or duplicated; data order matches FIFO order.
- bresp=2'b10 on the 2nd burst -> err=1 and stays 1; later OKAY responses do not clear it; rst clears it.
- Async rst during S_W beat 20 -> awvalid/wvalid/busy drop without a clock edge; after release, a new len=4 descriptor completes normally.
